// File: rtl/saadi_iter_accumulator.sv
// ---------------------------------------------------------------------------
// saadi_iter_accumulator
//
// Iterative mean accumulator for the SAADI-EC datapath. A run is started with
// an exponent t. The block then accepts 2^t unsigned samples over a
// valid/ready handshake. It returns their scaled mean (sum >> t) as a single
// registered result, and holds that result until the consumer takes it.
//
// Optional feature macro: SAADI_ACC_ROUND_EN
//   defined   : result is rounded half-up, (sum + 2^(t-1)) >> t for t > 0
//   undefined : result is truncated, sum >> t (no bias adder is built)
// Both builds have the same latency, handshake and reset behaviour.
// ---------------------------------------------------------------------------
module saadi_iter_accumulator #(
   parameter int WIDTH = 8,
   parameter int T_W   = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [T_W-1:0]   t,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic             busy
);

   // Largest run exponent, and the sum width that can hold 2^MAX_T full-scale
   // samples. With this width the sum cannot overflow for any legal t.
   localparam int MAX_T = (1 << T_W) - 1;
   localparam int ACC_W = WIDTH + MAX_T;

   localparam logic [MAX_T-1:0] CNT_ONES = '1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           state_q;
   state_t           state_d;

   logic [T_W-1:0]   t_r;       // exponent latched for the current run
   logic [ACC_W-1:0] acc;       // running sum of accepted samples
   logic [MAX_T-1:0] cnt;       // samples accepted so far in this run
   logic [WIDTH-1:0] res_q;     // registered result driven on out_data

   logic             start_ok;  // start arrives while idle
   logic             beat;      // a sample is accepted this cycle
   logic [MAX_T-1:0] last_cnt;  // value of cnt on the final beat, 2^t_r - 1
   logic             last_beat; // this beat completes the run
   logic [ACC_W-1:0] acc_sum;   // sum including the current sample
   logic [ACC_W-1:0] acc_biased;// sum ready for the final shift

`ifdef SAADI_ACC_ROUND_EN
   logic [ACC_W-1:0] round_bias;
`endif

   // Handshake qualifiers come straight from the state register. No path
   // exists from in_valid or out_ready into in_ready or out_valid.
   assign start_ok  = (state_q == S_IDLE) && start;
   assign beat      = (state_q == S_ACCUM) && in_valid;
   assign last_beat = beat && (cnt == last_cnt);

   // Build the terminal count 2^t_r - 1 as a mask of t_r low ones.
   always_comb begin
      last_cnt = ~(CNT_ONES << t_r);
   end

   // Sum with the current sample, plus the optional half-LSB rounding bias.
   // The bias is added before the shift and occupies bit (t_r - 1).
   always_comb begin
      acc_sum = acc + ACC_W'(in_data);
`ifdef SAADI_ACC_ROUND_EN
      round_bias = '0;
      if (t_r != '0) begin
         round_bias = ACC_W'(1) << (t_r - 1'b1);
      end
      acc_biased = acc_sum + round_bias;
`else
      acc_biased = acc_sum;
`endif
   end

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments. Every register
      // then samples pre-edge values, whatever the process evaluation order.
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic and the state-decoded handshake outputs.
   always_comb begin
      // NOTE: each output gets a default before the case statement. No branch
      // can then leave a value unassigned, so no latch is inferred.
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      unique case (state_q)
         S_IDLE: begin
            busy = 1'b0;
            if (start) begin
               state_d = S_ACCUM;
            end
         end
         S_ACCUM: begin
            in_ready = 1'b1;
            if (last_beat) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            out_valid = 1'b1;
            // A start in this same cycle is ignored. The next run needs a
            // start in the IDLE cycle that follows.
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Run datapath: latch t on start, accumulate and count accepted beats, and
   // register the scaled mean on the final beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         t_r   <= '0;
         acc   <= '0;
         cnt   <= '0;
         res_q <= '0;
      end else if (start_ok) begin
         t_r <= t;
         acc <= '0;
         cnt <= '0;
      end else if (beat) begin
         acc <= acc_sum;
         cnt <= cnt + 1'b1;
         if (last_beat) begin
            // Even at full scale the shifted sum fits in WIDTH bits, so
            // keeping the low bits loses nothing.
            res_q <= WIDTH'(acc_biased >> t_r);
         end
      end
   end

   // The result holds in res_q until the next run completes, so it stays
   // stable for as long as the consumer withholds out_ready.
   assign out_data = res_q;

endmodule

// File: tb/tb_saadi_iter_accumulator.sv
// ---------------------------------------------------------------------------
// tb_saadi_iter_accumulator
//
// Self-checking bench for saadi_iter_accumulator. Expected results come from
// the arithmetic mean of the samples driven in each run, truncated or rounded
// half-up to match the SAADI_ACC_ROUND_EN build.
// ---------------------------------------------------------------------------
module tb_saadi_iter_accumulator;

   localparam int WIDTH = 8;
   localparam int T_W   = 3;
   localparam int MAX_T = (1 << T_W) - 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [T_W-1:0]   t;
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_ready;
   logic             busy;

   int vectors     = 0;
   int miscompares = 0;

   int unsigned samples[$];

   saadi_iter_accumulator #(.WIDTH(WIDTH), .T_W(T_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .t        (t),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .out_valid(out_valid),
      .out_data (out_data),
      .out_ready(out_ready),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   // Drive and sample 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Mean of the current sample list over 2^tv samples.
   function automatic int unsigned model_mean(input int tv);
      int unsigned sum = 0;
      foreach (samples[i]) sum += samples[i];
`ifdef SAADI_ACC_ROUND_EN
      if (tv > 0) sum += (1 << (tv - 1));
`endif
      return sum >> tv;
   endfunction

   // Start a run with exponent tv and feed the sample list. Gaps appear with
   // probability gap_pct percent. With noise_start set, a start with t=MAX_T
   // is also driven on every beat, and the DUT must ignore it. The outputs
   // seen one cycle after the last beat are returned.
   task automatic drive_run(input int tv, input int gap_pct, input bit noise_start,
                            output bit rdy_at_start, output bit ready_ok,
                            output bit early_done, output logic ov_after,
                            output logic [WIDTH-1:0] od_after, output logic ir_after);
      ready_ok   = 1'b1;
      early_done = 1'b0;
      start = 1'b1;
      t     = T_W'(tv);
      tick();
      start = 1'b0;
      t     = '0;
      rdy_at_start = (in_ready === 1'b1);
      foreach (samples[i]) begin
         for (int g = 0; g < 4 && $urandom_range(99) < gap_pct; g++) begin
            in_valid = 1'b0;
            if (out_valid !== 1'b0) early_done = 1'b1;
            tick();
         end
         in_valid = 1'b1;
         in_data  = WIDTH'(samples[i]);
         if (noise_start) begin
            start = 1'b1;
            t     = T_W'(MAX_T);
         end
         if (in_ready !== 1'b1) ready_ok = 1'b0;
         if (out_valid !== 1'b0) early_done = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      start    = 1'b0;
      t        = '0;
      ov_after = out_valid;
      od_after = out_data;
      ir_after = in_ready;
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; t = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      vectors++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_outputs: got in_ready=%b out_valid=%b out_data=%0d busy=%b, want 0 0 0 0",
                  in_ready, out_valid, out_data, busy);
      end
   endtask

   // Run one full result through the DUT and check the beat-phase results.
   task automatic run_and_check(input string name, input int tv, input int gap_pct,
                                input bit noise_start);
      bit rs, rok, early;
      logic ov, ir;
      logic [WIDTH-1:0] od;
      int unsigned exp_v;
      exp_v = model_mean(tv);
      drive_run(tv, gap_pct, noise_start, rs, rok, early, ov, od, ir);
      vectors++;
      if (!rs || !rok || early) begin
         miscompares++;
         $display("FAIL %s_handshake: got ready_after_start=%b ready_each_beat=%b early_out_valid=%b, want 1 1 0",
                  name, rs, rok, early);
      end
      vectors++;
      if (ov !== 1'b1 || od !== WIDTH'(exp_v)) begin
         miscompares++;
         $display("FAIL %s_result: got out_valid=%b out_data=%0d, want 1 %0d", name, ov, od, exp_v);
      end
      vectors++;
      if (ir !== 1'b0) begin
         miscompares++;
         $display("FAIL %s_in_ready_drop: got in_ready=%b, want 0", name, ir);
      end
   endtask

   task automatic check_idle_after(input string name);
      handshake();
      vectors++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL %s_idle: got busy=%b out_valid=%b in_ready=%b, want 0 0 0",
                  name, busy, out_valid, in_ready);
      end
   endtask

   task automatic test_basic();
      samples = '{10, 20, 30, 43};
      run_and_check("basic_t2", 2, 0, 1'b0);
      check_idle_after("basic_t2");
   endtask

   task automatic test_t0();
      samples = '{200};
      run_and_check("single_t0", 0, 0, 1'b0);
      check_idle_after("single_t0");
   endtask

   task automatic test_t7_gaps();
      samples.delete();
      for (int i = 0; i < 128; i++) samples.push_back(255);
      run_and_check("full_t7", 7, 30, 1'b0);
      check_idle_after("full_t7");
   endtask

   task automatic test_hold();
      int unsigned exp_v;
      samples = '{100, 51};
      exp_v = model_mean(1);
      run_and_check("hold_t1", 1, 0, 1'b0);
      for (int c = 0; c < 5; c++) begin
         start = (c == 2);
         t     = T_W'(3);
         tick();
         vectors++;
         if (out_valid !== 1'b1 || out_data !== WIDTH'(exp_v)) begin
            miscompares++;
            $display("FAIL hold_stable_%0d: got out_valid=%b out_data=%0d, want 1 %0d",
                     c, out_valid, out_data, exp_v);
         end
      end
      // Consumer takes the result while start is high: the start is dropped.
      start = 1'b1;
      t     = T_W'(2);
      handshake();
      start = 1'b0;
      vectors++;
      if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL hold_start_on_exit: got busy=%b in_ready=%b out_valid=%b, want 0 0 0",
                  busy, in_ready, out_valid);
      end
      tick();
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL hold_stays_idle: got busy=%b, want 0", busy);
      end
   endtask

   task automatic test_reset_mid();
      start = 1'b1;
      t     = T_W'(2);
      tick();
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1;
         in_data  = WIDTH'(50 + i);
         tick();
      end
      rst = 1'b1;
      tick();
      rst      = 1'b0;
      in_valid = 1'b0;
      vectors++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL midrun_reset: got in_ready=%b out_valid=%b out_data=%0d busy=%b, want 0 0 0 0",
                  in_ready, out_valid, out_data, busy);
      end
      samples = '{7, 8};
      run_and_check("after_reset_t1", 1, 0, 1'b0);
      check_idle_after("after_reset_t1");
   endtask

   task automatic test_start_in_accum();
      samples = '{33, 90};
      run_and_check("start_in_accum", 1, 20, 1'b1);
      check_idle_after("start_in_accum");
   endtask

   task automatic test_random();
      for (int r = 0; r < 25; r++) begin
         int tv;
         int unsigned exp_v;
         int hold;
         tv = $urandom_range(0, 5);
         samples.delete();
         for (int i = 0; i < (1 << tv); i++) samples.push_back($urandom_range(0, 255));
         exp_v = model_mean(tv);
         run_and_check($sformatf("rand%0d_t%0d", r, tv), tv, 25, 1'($urandom_range(0, 1)));
         hold = $urandom_range(0, 3);
         for (int c = 0; c < hold; c++) begin
            tick();
            vectors++;
            if (out_valid !== 1'b1 || out_data !== WIDTH'(exp_v)) begin
               miscompares++;
               $display("FAIL rand%0d_hold: got out_valid=%b out_data=%0d, want 1 %0d",
                        r, out_valid, out_data, exp_v);
            end
         end
         check_idle_after($sformatf("rand%0d", r));
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_t0();
      test_t7_gaps();
      test_hold();
      test_reset_mid();
      test_start_in_accum();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
      $fatal(1, "time limit");
   end

endmodule
